// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - multi-channel timer with shared prescaler, W1C status, bus slave
module timer_multi #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 16,
   parameter int ADDR_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs_,
   input  logic              as_,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic              rdy_,
   output logic              irq
);
   localparam int SLOT_W = ADDR_W - 2;
   localparam logic [SLOT_W-1:0] STAT_SLOT = SLOT_W'(NUM_CH);

   logic [NUM_CH-1:0]  start_q, start_d, mode_q, mode_d, ie_q, ie_d;
   logic [NUM_CH-1:0]  status_q, status_d, expire;
   logic [CNT_W-1:0]   expr_q [NUM_CH];
   logic [CNT_W-1:0]   expr_d [NUM_CH];
   logic [CNT_W-1:0]   cnt_q  [NUM_CH];
   logic [CNT_W-1:0]   cnt_d  [NUM_CH];
   logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
   logic [31:0]        rd_data_q, rd_data_d;
   logic               rdy_q, rdy_d, irq_q, irq_d;
   logic               access, wr_en, rd_en, tick;
   logic [SLOT_W-1:0]  slot;
   logic [1:0]         reg_sel;

   assign access  = !cs_ && !as_;
   assign wr_en   = access && !rw;
   assign rd_en   = access && rw;
   assign slot    = addr[ADDR_W-1:2];
   assign reg_sel = addr[1:0];
   assign tick    = (pcnt_q == presc_q);

   // Free-running prescaler; a PRESC write restarts the phase from zero.
   always_comb begin
      presc_d = presc_q;
      pcnt_d  = tick ? '0 : pcnt_q + PRESC_W'(1);
      if (wr_en && slot == STAT_SLOT && reg_sel == 2'd1) begin
         presc_d = wr_data[PRESC_W-1:0];
         pcnt_d  = '0;
      end
   end

   always_comb begin
      start_d  = start_q;
      mode_d   = mode_q;
      ie_d     = ie_q;
      status_d = status_q;
      expire   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         expr_d[i] = expr_q[i];
         cnt_d[i]  = cnt_q[i];
         if (wr_en && slot == SLOT_W'(i) && reg_sel == 2'd2) begin
            cnt_d[i] = wr_data[CNT_W-1:0];
         end else if (start_q[i] && tick && cnt_q[i] == expr_q[i]) begin
            expire[i] = 1'b1;
            cnt_d[i]  = '0;
            if (!mode_q[i]) start_d[i] = 1'b0;
         end else if (start_q[i] && tick) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
         // Bus CTRL write overrides the one-shot auto-clear above.
         if (wr_en && slot == SLOT_W'(i) && reg_sel == 2'd0) begin
            ie_d[i]    = wr_data[2];
            mode_d[i]  = wr_data[1];
            start_d[i] = wr_data[0];
         end
         if (wr_en && slot == SLOT_W'(i) && reg_sel == 2'd1) begin
            expr_d[i] = wr_data[CNT_W-1:0];
         end
      end
      if (wr_en && slot == STAT_SLOT && reg_sel == 2'd0) begin
         status_d = status_q & ~wr_data[NUM_CH-1:0];
      end
      status_d = status_d | expire;
      irq_d    = |(status_d & ie_d);
   end

   always_comb begin
      rd_data_d = '0;
      rdy_d     = !access;
      if (rd_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (slot == SLOT_W'(i)) begin
               case (reg_sel)
                  2'd0:    rd_data_d = {29'd0, ie_q[i], mode_q[i], start_q[i]};
                  2'd1:    rd_data_d = 32'(expr_q[i]);
                  2'd2:    rd_data_d = 32'(cnt_q[i]);
                  default: rd_data_d = '0;
               endcase
            end
         end
         if (slot == STAT_SLOT) begin
            case (reg_sel)
               2'd0:    rd_data_d = 32'(status_q);
               2'd1:    rd_data_d = 32'(presc_q);
               default: rd_data_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q   <= '0;
         mode_q    <= '0;
         ie_q      <= '0;
         status_q  <= '0;
         expr_q    <= '{default: '0};
         cnt_q     <= '{default: '0};
         presc_q   <= '0;
         pcnt_q    <= '0;
         rd_data_q <= '0;
         rdy_q     <= 1'b1;
         irq_q     <= 1'b0;
      end else begin
         start_q   <= start_d;
         mode_q    <= mode_d;
         ie_q      <= ie_d;
         status_q  <= status_d;
         expr_q    <= expr_d;
         cnt_q     <= cnt_d;
         presc_q   <= presc_d;
         pcnt_q    <= pcnt_d;
         rd_data_q <= rd_data_d;
         rdy_q     <= rdy_d;
         irq_q     <= irq_d;
      end
   end

   assign rd_data = rd_data_q;
   assign rdy_    = rdy_q;
   assign irq     = irq_q;
endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - directed self-checking bench for timer_multi
module tb_timer_multi;
   logic        clk = 1'b0;
   logic        reset, cs_, as_, rw;
   logic [4:0]  addr;
   logic [31:0] wr_data, rd_data;
   logic        rdy_, irq;
   int          n_chk = 0, n_bad = 0;
   logic [31:0] rv;

   always #5 clk = ~clk;

   timer_multi #(.NUM_CH(4), .CNT_W(32), .PRESC_W(16), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
      @(posedge clk);
      #1;
      cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
      @(posedge clk);
      #1;
      d = rd_data;
      cs_ = 1'b1; as_ = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
      tick_n(2);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rdy", {31'd0, rdy_}, 1);
      chk("rst_irq", {31'd0, irq}, 0);
      reset = 1'b1;
      tick_n(1);
      for (int s = 0; s < 5; s++) begin
         for (int r = 0; r < 4; r++) begin
            bus_read(5'(s * 4 + r), rv);
            chk($sformatf("rst_reg_s%0d_r%0d", s, r), rv, 0);
         end
      end
      chk("rd_rdy_low", {31'd0, rdy_}, 0);

      // ch0 one-shot, EXPR=5, PRESC=0: irq 7 clocks after the CTRL write is driven
      bus_write(5'd1, 32'd5);
      bus_write(5'd0, 32'h5);
      tick_n(5);
      chk("os_irq_early", {31'd0, irq}, 0);
      tick_n(1);
      chk("os_irq_set", {31'd0, irq}, 1);
      bus_read(5'd2, rv);  chk("os_cnt_zero", rv, 0);
      bus_read(5'd0, rv);  chk("os_ctrl", rv, 32'h4);
      tick_n(5);
      bus_read(5'd2, rv);  chk("os_cnt_hold", rv, 0);
      bus_write(5'd16, 32'h1);
      chk("os_irq_clr", {31'd0, irq}, 0);
      bus_write(5'd0, 32'h0);

      // ch1 periodic EXPR=3 PRESC=2: expiries at P+12, P+24, P+36
      bus_write(5'd17, 32'd2);           // P
      bus_write(5'd5, 32'd3);            // P+1
      bus_write(5'd4, 32'h7);            // P+2
      tick_n(9);                         // P+11
      chk("per_irq_early", {31'd0, irq}, 0);
      tick_n(1);                         // P+12
      chk("per_irq_set", {31'd0, irq}, 1);
      bus_read(5'd16, rv);               // P+13
      chk("per_status", rv, 32'h2);
      tick_n(10);                        // P+23
      bus_write(5'd16, 32'h2);           // P+24, collides with expiry
      chk("per_w1c_collide_irq", {31'd0, irq}, 1);
      bus_read(5'd16, rv);               // P+25
      chk("per_w1c_collide", rv, 32'h2);
      bus_write(5'd16, 32'h2);           // P+26
      chk("per_w1c_irq", {31'd0, irq}, 0);
      bus_read(5'd16, rv);               // P+27
      chk("per_w1c_status", rv, 0);
      tick_n(8);                         // P+35
      chk("per_irq_p35", {31'd0, irq}, 0);
      tick_n(1);                         // P+36
      chk("per_irq_p36", {31'd0, irq}, 1);
      bus_write(5'd4, 32'h0);
      bus_write(5'd16, 32'h2);
      chk("per_irq_off", {31'd0, irq}, 0);

      // ch2 wrap then expiry; COUNTER write beats a same-cycle expiry
      bus_write(5'd17, 32'd0);
      bus_write(5'd9, 32'd4);            // Q
      bus_write(5'd10, 32'hFFFF_FFFE);   // Q+1
      bus_write(5'd8, 32'h3);            // Q+2
      bus_read(5'd10, rv); chk("wrap_fffe", rv, 32'hFFFF_FFFE);
      bus_read(5'd10, rv); chk("wrap_ffff", rv, 32'hFFFF_FFFF);
      bus_read(5'd10, rv); chk("wrap_zero", rv, 32'h0);
      bus_read(5'd10, rv); chk("wrap_one", rv, 32'h1);
      bus_read(5'd16, rv); chk("wrap_no_exp", rv, 0);     // Q+7
      tick_n(2);                                           // Q+9 expiry
      bus_read(5'd16, rv); chk("wrap_exp", rv, 32'h4);    // Q+10
      bus_write(5'd16, 32'h4);                             // Q+11
      tick_n(2);                                           // Q+13
      bus_write(5'd10, 32'h100);                           // Q+14
      bus_read(5'd16, rv); chk("cw_status", rv, 0);
      bus_read(5'd10, rv); chk("cw_cnt", rv, 32'h101);
      bus_write(5'd8, 32'h0);

      // bus behaviour
      bus_write(5'd13, 32'h1234_5678);
      chk("wr_rd_data", rd_data, 0);
      chk("wr_rdy", {31'd0, rdy_}, 0);
      bus_read(5'd25, rv);
      chk("unmapped_rd", rv, 0);
      chk("unmapped_rdy", {31'd0, rdy_}, 0);
      bus_read(5'd1, rv);
      chk("b2b_expr0", rv, 32'd5);
      chk("b2b_rdy0", {31'd0, rdy_}, 0);
      bus_read(5'd13, rv);
      chk("b2b_expr3", rv, 32'h1234_5678);
      chk("b2b_rdy3", {31'd0, rdy_}, 0);
      tick_n(1);
      chk("idle_rdy", {31'd0, rdy_}, 1);
      chk("idle_rd_data", rd_data, 0);
      cs_ = 1'b0;
      tick_n(1);
      chk("cs_only_rdy", {31'd0, rdy_}, 1);
      cs_ = 1'b1;
      bus_write(5'd3, 32'hFFFF_FFFF);
      bus_read(5'd3, rv);
      chk("reserved_rd", rv, 0);

      // async reset while all channels run
      bus_write(5'd0, 32'h7);
      bus_write(5'd4, 32'h7);
      bus_write(5'd8, 32'h7);
      bus_write(5'd12, 32'h7);
      for (int k = 0; k < 40 && irq !== 1'b1; k++) tick_n(1);
      chk("run_irq", {31'd0, irq}, 1);
      bus_read(5'd13, rv);
      chk("pre_rst_rd", rv, 32'h1234_5678);
      #2 reset = 1'b0;
      #1;
      chk("async_rd_data", rd_data, 0);
      chk("async_rdy", {31'd0, rdy_}, 1);
      chk("async_irq", {31'd0, irq}, 0);
      tick_n(2);
      reset = 1'b1;
      tick_n(5);
      for (int c = 0; c < 4; c++) begin
         bus_read(5'(c * 4 + 2), rv);
         chk($sformatf("post_rst_cnt%0d", c), rv, 0);
      end
      bus_read(5'd0, rv);  chk("post_rst_ctrl0", rv, 0);
      bus_read(5'd16, rv); chk("post_rst_status", rv, 0);
      chk("post_rst_irq", {31'd0, irq}, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
